// File: rtl/spi_bus_arbiter_pkg.sv
// Shared definitions for the SPI bus arbiter: FSM state encoding and a
// constant-function log2 helper used to size index ports.
package spi_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible (req & ~mask) bit found
// searching upward from ptr, wrapping modulo N.
module rr_pick
    import spi_bus_arbiter_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] cand;

    // Walk offsets from the far end so the nearest eligible offset wins last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand] && !mask[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI bus between N_REQ engines: round-robin grants, a guard gap
// of all-high chip selects between holders, and a hold-time watchdog.
module spi_bus_arbiter
    import spi_bus_arbiter_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter bit CPOL       = 1'b0,
    parameter int GAP_CYCLES = 4,
    parameter int MAX_HOLD   = 65535,
    localparam int IW        = clog2(N_REQ)
) (
    input  logic             sys_clk,
    input  logic             n_rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    gnt_idx,
    output logic             busy,
    input  logic [N_REQ-1:0] eng_sclk,
    input  logic [N_REQ-1:0] eng_mosi,
    input  logic [N_REQ-1:0] eng_n_cs,
    output logic [N_REQ-1:0] eng_miso,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic [N_REQ-1:0] n_cs_bus,
    output logic             timeout_err,
    output arb_state_t       dbg_state
);

    localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);
    localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYCLES - 1);

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    idx_q, ptr_q, pick_idx, next_ptr;
    logic             pick_valid;
    logic [N_REQ-1:0] mask_q, holder_oh;
    logic [15:0]      hold_q;
    logic [7:0]       gap_q;
    logic             tout_q, sclk_q, mosi_q;
    logic [N_REQ-1:0] ncs_q;
    logic             grant_start, release_go, watchdog;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req   (req),
        .mask  (mask_q),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign holder_oh = N_REQ'(1) << idx_q;
    assign next_ptr  = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) state_q <= ARB_IDLE;
        else        state_q <= state_d;
    end

    // A holder dropping req wins over the watchdog in the same cycle.
    always_comb begin
        state_d     = state_q;
        grant_start = 1'b0;
        release_go  = 1'b0;
        watchdog    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d     = ARB_GRANT;
                    grant_start = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (!req[idx_q]) begin
                    state_d    = ARB_GAP;
                    release_go = 1'b1;
                end else if (hold_q == HOLD_LAST) begin
                    state_d    = ARB_GAP;
                    release_go = 1'b1;
                    watchdog   = 1'b1;
                end
            end
            ARB_GAP: begin
                if (gap_q == GAP_LAST) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            idx_q  <= '0;
            ptr_q  <= '0;
            mask_q <= '0;
            hold_q <= '0;
            gap_q  <= '0;
            tout_q <= 1'b0;
            sclk_q <= CPOL;
            mosi_q <= 1'b0;
            ncs_q  <= '1;
        end else begin
            tout_q <= watchdog;
            // A timed-out engine stays masked until its req drops once.
            mask_q <= (mask_q & req) | (watchdog ? holder_oh : '0);
            if (grant_start) begin
                idx_q  <= pick_idx;
                hold_q <= '0;
            end else if (state_q == ARB_GRANT) begin
                hold_q <= hold_q + 16'd1;
            end
            if (release_go) begin
                ptr_q <= next_ptr;
                gap_q <= '0;
            end else if (state_q == ARB_GAP) begin
                gap_q <= gap_q + 8'd1;
            end
            if (state_q == ARB_GRANT) begin
                sclk_q <= eng_sclk[idx_q];
                mosi_q <= eng_mosi[idx_q];
                ncs_q  <= ~holder_oh | eng_n_cs;
            end else begin
                sclk_q <= CPOL;
                mosi_q <= 1'b0;
                ncs_q  <= '1;
            end
        end
    end

    assign gnt         = (state_q == ARB_GRANT) ? holder_oh : '0;
    assign gnt_idx     = idx_q;
    assign busy        = (state_q != ARB_IDLE);
    assign eng_miso    = (state_q == ARB_GRANT) ? (holder_oh & {N_REQ{miso}}) : '0;
    assign sclk        = sclk_q;
    assign mosi        = mosi_q;
    assign n_cs_bus    = ncs_q;
    assign timeout_err = tout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed vector table, hand-written corner
// sequences and randomized engines checked against a cycle-level reference.
module tb_spi_bus_arbiter;
    import spi_bus_arbiter_pkg::*;

    localparam int N   = 3;
    localparam int GAP = 4;
    localparam int MH  = 100;

    logic       sys_clk, n_rst;
    logic [2:0] req, gnt, eng_sclk, eng_mosi, eng_n_cs, eng_miso, n_cs_bus;
    logic [1:0] gnt_idx;
    logic       busy, sclk, mosi, miso, timeout_err;
    arb_state_t dbg_state;

    int n_vec = 0;
    int n_miss = 0;

    spi_bus_arbiter #(.N_REQ(N), .CPOL(1'b0), .GAP_CYCLES(GAP), .MAX_HOLD(MH)) dut (
        .sys_clk(sys_clk), .n_rst(n_rst), .req(req), .gnt(gnt), .gnt_idx(gnt_idx),
        .busy(busy), .eng_sclk(eng_sclk), .eng_mosi(eng_mosi), .eng_n_cs(eng_n_cs),
        .eng_miso(eng_miso), .sclk(sclk), .mosi(mosi), .miso(miso),
        .n_cs_bus(n_cs_bus), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1);
    end

    // ---------------- scoreboard helpers ----------------
    logic [1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_wait(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: no event within cycle budget, required one at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    int         m_holder, m_last, m_hold, m_gap, m_ptr;
    logic [2:0] m_mask, m_ncs;
    logic       m_tout, m_sclk, m_mosi;

    task automatic model_reset();
        m_holder = -1; m_last = 0; m_hold = 0; m_gap = 0; m_ptr = 0;
        m_mask = '0; m_ncs = '1; m_tout = 0; m_sclk = 0; m_mosi = 0;
    endtask

    task automatic model_step();
        logic [2:0] nmask;
        int c;
        nmask  = m_mask & req;
        m_tout = 0;
        if (m_holder >= 0) begin
            m_ncs = '1;
            m_ncs[m_holder] = eng_n_cs[m_holder];
            m_sclk = eng_sclk[m_holder];
            m_mosi = eng_mosi[m_holder];
            if (!req[m_holder] || m_hold == MH - 1) begin
                if (req[m_holder]) begin
                    m_tout = 1;
                    nmask[m_holder] = 1'b1;
                end
                m_ptr = (m_holder + 1) % N;
                m_gap = GAP;
                m_holder = -1;
            end else begin
                m_hold++;
            end
        end else begin
            m_ncs = '1; m_sclk = 0; m_mosi = 0;
            if (m_gap > 0) m_gap--;
            else begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (req[c] && !m_mask[c]) begin
                        m_holder = c; m_last = c; m_hold = 0;
                        break;
                    end
                end
            end
        end
        m_mask = nmask;
    endtask

    task automatic model_check();
        logic [2:0] eg, em;
        eg = (m_holder >= 0) ? 3'(1 << m_holder) : 3'b000;
        em = miso ? eg : 3'b000;
        check("m_gnt", 32'(gnt), 32'(eg));
        check("m_gnt_idx", 32'(gnt_idx), 32'(m_last));
        check("m_busy", 32'(busy), 32'((m_holder >= 0) || (m_gap > 0)));
        check("m_timeout_err", 32'(timeout_err), 32'(m_tout));
        check("m_n_cs_bus", 32'(n_cs_bus), 32'(m_ncs));
        check("m_sclk", 32'(sclk), 32'(m_sclk));
        check("m_mosi", 32'(mosi), 32'(m_mosi));
        check("m_eng_miso", 32'(eng_miso), 32'(em));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        model_step();
        @(posedge sys_clk);
        #1;
        model_check();
    endtask

    task automatic do_reset();
        n_rst = 0; req = '0; eng_sclk = '0; eng_mosi = '0; eng_n_cs = '1; miso = 0;
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        n_rst = 1;
    endtask

    bit e_req[3], e_on[3];
    int e_left[3], e_idle[3];
    int hold_lo, hold_hi, idle_lo, idle_hi;

    task automatic engine_drive();
        for (int i = 0; i < N; i++) begin
            if (e_req[i]) begin
                if (gnt[i]) e_on[i] = 1;
                if (e_on[i]) begin
                    if (e_left[i] == 0) begin
                        e_req[i] = 0; e_on[i] = 0;
                        e_idle[i] = $urandom_range(idle_hi, idle_lo);
                    end else e_left[i]--;
                end
            end else if (e_idle[i] == 0) begin
                e_req[i] = 1;
                e_left[i] = $urandom_range(hold_hi, hold_lo);
            end else e_idle[i]--;
            req[i] = e_req[i];
            eng_n_cs[i] = gnt[i] ? 1'b0 : 1'($urandom_range(1, 0));
        end
        eng_sclk = 3'($urandom);
        eng_mosi = 3'($urandom);
        miso = 1'($urandom);
    endtask

    task automatic run_engines(input int cycles, input bit track_order);
        logic [2:0] prev;
        logic [1:0] gi;
        int zeros;
        bit seen;
        prev = '0; zeros = 0; seen = 0;
        for (int c = 0; c < cycles; c++) begin
            engine_drive();
            tick();
            check("gnt_onehot", 32'($onehot0(gnt)), 32'(1));
            if (gnt != 3'b000 && prev == 3'b000) begin
                gi = 0;
                for (int i = 0; i < N; i++) if (gnt[i]) gi = 2'(i);
                if (seen) check("gap_len_min", 32'(zeros >= GAP + 1), 32'(1));
                if (track_order) begin
                    if (seen) check("gap_len", 32'(zeros), 32'(GAP + 1));
                    if (exp_q.size() > 0) check("grant_order", 32'(gi), 32'(exp_q.pop_front()));
                end
                seen = 1; zeros = 0;
            end else if (gnt == 3'b000) begin
                zeros++;
            end
            prev = gnt;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [2:0] req;
        logic [2:0] ncs_in;
        logic       sclk_in;
        logic [2:0] exp_gnt;
        logic [2:0] exp_ncs;
        logic       exp_sclk;
        logic       exp_busy;
    } vec_t;

    vec_t vt[10];

    initial begin
        int n, zeros, bad;
        bit ok;
        vt[0] = '{3'b001, 3'b111, 1'b0, 3'b001, 3'b111, 1'b0, 1'b1};
        vt[1] = '{3'b001, 3'b110, 1'b0, 3'b001, 3'b110, 1'b0, 1'b1};
        vt[2] = '{3'b001, 3'b110, 1'b1, 3'b001, 3'b110, 1'b1, 1'b1};
        vt[3] = '{3'b001, 3'b110, 1'b0, 3'b001, 3'b110, 1'b0, 1'b1};
        vt[4] = '{3'b000, 3'b111, 1'b0, 3'b000, 3'b111, 1'b0, 1'b1};
        vt[5] = '{3'b000, 3'b111, 1'b0, 3'b000, 3'b111, 1'b0, 1'b1};
        vt[6] = '{3'b100, 3'b111, 1'b0, 3'b000, 3'b111, 1'b0, 1'b1};
        vt[7] = '{3'b100, 3'b111, 1'b0, 3'b000, 3'b111, 1'b0, 1'b1};
        vt[8] = '{3'b100, 3'b111, 1'b0, 3'b000, 3'b111, 1'b0, 1'b0};
        vt[9] = '{3'b100, 3'b111, 1'b0, 3'b100, 3'b111, 1'b0, 1'b1};

        // reset state
        do_reset();
        check("rst_gnt", 32'(gnt), 32'(3'b000));
        check("rst_gnt_idx", 32'(gnt_idx), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_timeout_err", 32'(timeout_err), 32'(0));
        check("rst_n_cs_bus", 32'(n_cs_bus), 32'(3'b111));
        check("rst_sclk", 32'(sclk), 32'(0));
        check("rst_mosi", 32'(mosi), 32'(0));

        // single request, release, gap, then a request that arrives mid-gap
        foreach (vt[i]) begin
            req = vt[i].req; eng_n_cs = vt[i].ncs_in; eng_sclk = {2'b00, vt[i].sclk_in};
            eng_mosi = '0; miso = 0;
            tick();
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vt[i].exp_gnt));
            check($sformatf("vec%0d_n_cs_bus", i), 32'(n_cs_bus), 32'(vt[i].exp_ncs));
            check($sformatf("vec%0d_sclk", i), 32'(sclk), 32'(vt[i].exp_sclk));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].exp_busy));
        end

        // miso routing with holder 2
        for (int k = 0; k < 4; k++) begin
            miso = 1'(k % 2);
            #1;
            check("miso_route", 32'(eng_miso), 32'(miso ? 3'b100 : 3'b000));
        end

        // contention with noisy non-holders
        do_reset();
        hold_lo = 20; hold_hi = 20; idle_lo = 2; idle_hi = 2;
        for (int i = 0; i < N; i++) begin
            e_req[i] = 1; e_on[i] = 0; e_left[i] = 20; e_idle[i] = 0;
        end
        exp_q = {2'd0, 2'd1, 2'd2, 2'd0};
        run_engines(110, 1'b1);
        check("order_complete", 32'(exp_q.size()), 32'(0));

        // watchdog
        do_reset();
        req = 3'b010; eng_n_cs = 3'b101;
        ok = 0;
        for (int w = 0; w < 10 && !ok; w++) begin
            tick();
            ok = gnt[1];
        end
        if (!ok) fail_wait("wd_grant_wait");
        req[0] = 1'b1;
        n = 1;
        for (int w = 0; w < 300; w++) begin
            tick();
            if (gnt[1]) n++;
            else break;
        end
        check("wd_hold_len", 32'(n), 32'(MH));
        check("wd_timeout_pulse", 32'(timeout_err), 32'(1));
        zeros = 1;
        tick();
        check("wd_timeout_clear", 32'(timeout_err), 32'(0));
        if (gnt == 3'b000) zeros++;
        for (int w = 0; w < 20 && gnt == 3'b000; w++) begin
            tick();
            if (gnt == 3'b000) zeros++;
        end
        check("wd_gap_zeros", 32'(zeros), 32'(GAP + 1));
        check("wd_next_gnt", 32'(gnt), 32'(3'b001));
        repeat (5) tick();
        req[0] = 1'b0;
        bad = 0;
        for (int w = 0; w < 15; w++) begin
            tick();
            if (gnt != 3'b000) bad++;
        end
        check("wd_masked", 32'(bad), 32'(0));
        req[1] = 1'b0;
        tick();
        req[1] = 1'b1;
        tick();
        check("wd_regrant", 32'(gnt), 32'(3'b010));

        // asynchronous reset in the middle of a frame
        eng_n_cs = 3'b101; eng_sclk = 3'b010;
        tick();
        tick();
        check("frame_n_cs_bus", 32'(n_cs_bus), 32'(3'b101));
        check("frame_sclk", 32'(sclk), 32'(1));
        #2;
        n_rst = 0;
        #1;
        check("arst_n_cs_bus", 32'(n_cs_bus), 32'(3'b111));
        check("arst_sclk", 32'(sclk), 32'(0));
        check("arst_gnt", 32'(gnt), 32'(3'b000));
        check("arst_busy", 32'(busy), 32'(0));
        model_reset();
        req = '0; eng_n_cs = '1; eng_sclk = '0; eng_mosi = '0; miso = 0;
        @(posedge sys_clk);
        #1;
        n_rst = 1;
        req = 3'b111;
        tick();
        check("arst_ptr_restart", 32'(gnt), 32'(3'b001));

        // randomized engines, hold times straddling the watchdog limit
        hold_lo = 1; hold_hi = 110; idle_lo = 0; idle_hi = 6;
        for (int i = 0; i < N; i++) begin
            e_req[i] = 0; e_on[i] = 0; e_left[i] = 0;
            e_idle[i] = $urandom_range(6, 0);
        end
        run_engines(1500, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one physical SPI bus (sclk/mosi/miso) between N_REQ SPI master engines, each owning its own chip select.
- Typical users: the D12/D13/D14 ADC engines, or the power potentiometers plus the housekeeping autopoll engine.
- Grants are round-robin, one holder at a time, with a guard gap between holders and a hold-time watchdog.
- Sits between the if_spi-style engines and the board pins, on the sys_clk domain.

Parameters:
- N_REQ, 3, number of requesting SPI engines (2..8)
- CPOL, 0, idle level driven on bus sclk when no grant is active
- GAP_CYCLES, 4, sys_clk cycles with all n_cs high between two grants (1..255)
- MAX_HOLD, 65535, max sys_clk cycles a grant may be held before forced release (16-bit counter)

Ports:
- sys_clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- req  in  N_REQ  per-engine bus request, level; held high until done
- gnt  out  N_REQ  one-hot grant; engine may drive its SPI signals only while its bit is high
- gnt_idx  out  $clog2(N_REQ)  index of current/last holder
- busy  out  1  high while any grant is active or the gap is running
- eng_sclk  in  N_REQ  per-engine sclk
- eng_mosi  in  N_REQ  per-engine mosi
- eng_n_cs  in  N_REQ  per-engine chip select, active low
- eng_miso  out  N_REQ  per-engine miso; holder gets bus miso, others get 0
- sclk  out  1  bus sclk
- mosi  out  1  bus mosi
- miso  in  1  bus miso
- n_cs_bus  out  N_REQ  bus chip selects, active low
- timeout_err  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (async, n_rst=0) values:
  - state=IDLE; gnt=0; gnt_idx=0; busy=0; timeout_err=0.
  - sclk=CPOL; mosi=0; n_cs_bus=all ones; round-robin pointer=0.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If any req bit is high, pick the first set bit searching upward from pointer, wrapping modulo N_REQ.
  - Next cycle: gnt bit for the winner high, gnt_idx=winner, busy=1, enter GRANT. Grant latency is one cycle from req sampled high.
- GRANT:
  - Bus outputs are registered copies of the holder's eng_sclk/eng_mosi/eng_n_cs; one-cycle pin latency.
  - n_cs_bus for non-holders is forced to 1; sclk for non-holders is ignored.
  - eng_miso[holder]=miso, combinational; all other eng_miso bits are 0.
  - Hold counter increments every cycle.
  - Holder's req falls: gnt cleared the next cycle, pointer=holder+1 (wrapping), enter GAP.
  - Hold counter reaches MAX_HOLD-1 with req still high: forced release. gnt cleared, timeout_err pulses for one cycle, pointer advances, enter GAP.
  - The timed-out engine's req is masked until it drops low once, so it cannot re-grant while still asserting the stale request.
- GAP:
  - sclk=CPOL, mosi=0, n_cs_bus all ones, gnt=0, busy=1.
  - Counts GAP_CYCLES cycles, then goes to IDLE with busy=0.
  - Requests arriving during GAP are only evaluated in IDLE.
- Simultaneous requests: the round-robin pointer decides; the last holder has lowest priority next time.
- req rising on a non-holder during GRANT: no effect until the next IDLE arbitration.
- Holder drops req in the same cycle the watchdog fires: treat as normal release, no timeout_err.
- n_rst low mid-transfer: n_cs_bus goes all high and sclk goes to CPOL immediately (async). The engine must restart its frame after reset.
- Single requester: repeated grants to the same index, each separated by GAP_CYCLES+1 cycles minimum.
- Engines must check gnt before asserting their own n_cs. Data driven before the grant is not forwarded.

Decomposition:
- Shared package/defines: ARB_IDLE/ARB_GRANT/ARB_GAP state encodings; the clog2 helper.
- One sub-module, rr_pick: combinational, takes req, mask and pointer, returns winner index plus a valid flag. It is reused by the engine-level arbiters.
- Bus muxing and the watchdog stay in the top.

Test Plan:
- Single request: req=3'b001 at cycle 0 -> gnt=001 at cycle 1; eng_n_cs[0]=0 appears on n_cs_bus[0] one cycle later. Drop req -> gnt=0, 4 cycles of all-high n_cs, busy=0 after the gap.
- Contention: req=3'b111 held; each engine drops req after 20 cycles and re-raises it 2 cycles later -> grant order 0,1,2,0; gap of 4 cycles between grants; gnt never has two bits set.
- miso routing: holder=2, bus miso toggles 0101 -> eng_miso[2] follows; eng_miso[1:0] stay 0.
- Watchdog: MAX_HOLD=100, req[1] held forever -> gnt[1] drops at hold count 100 and timeout_err=1 for exactly one cycle. Engine 1 is not re-granted until req[1] goes low then high. Engine 0 requesting meanwhile is granted after the gap.
- Reset mid-grant: n_rst low while holder 0 has n_cs low and sclk=1 -> same cycle n_cs_bus=111, sclk=CPOL, gnt=0. After release, the pointer restarts at 0.
- Non-holder noise: holder=0, engine 1 toggles eng_sclk/eng_n_cs -> bus pins show only engine 0 activity; n_cs_bus[1] stays 1.
